bus_generator_arbiter: RTL and testbench

- Parameterized shared-bus generator and arbiter connecting `drvrs` devices on each of `bits` independent buses.
- Each device exposes an output FIFO: `pndng`/`D_pop`/`pop` toward the bus, and an input FIFO via `push`/`D_push`.
- The block arbitrates round-robin among devices with pending packets, pops one packet and routes it to the device named in its header, or to all other devices for broadcast.
- It sits between the per-device FIFO drivers and the device-side monitors of the bus subsystem.

---
 rtl/bus_generator_arbiter_if.sv | 29 ++
 rtl/bus_generator_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_generator_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bus_generator_arbiter_if.sv
// Device-side bundle of the shared-bus arbiter: output FIFO heads toward the bus,
// input FIFO write strobes back to the devices.
interface bus_generator_arbiter_if #(
   parameter int bits    = 1,
   parameter int drvrs   = 4,
   parameter int pckg_sz = 16
);
   logic [bits-1:0][drvrs-1:0]              pndng;
   logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
   logic [bits-1:0][drvrs-1:0]              pop;
   logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;
   logic [bits-1:0][drvrs-1:0]              push;

   modport master (
      input  pndng,
      input  D_pop,
      output pop,
      output D_push,
      output push
   );

   modport slave (
      output pndng,
      output D_pop,
      input  pop,
      input  D_push,
      input  push
   );
endinterface

// File: rtl/bus_generator_arbiter.sv
// Round-robin shared-bus arbiter: per bus, pops one packet from a pending device
// and delivers it to the addressed device, or to every other device on broadcast.
module bus_generator_arbiter #(
   parameter int         bits      = 1,
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic                   clk,
   input  logic                   reset,
   bus_generator_arbiter_if.master bus
);

   localparam int PW = $clog2(drvrs);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      PUSH = 2'd2
   } state_t;

   wire [bits-1:0][drvrs-1:0]              pop_w;
   wire [bits-1:0][drvrs-1:0]              push_w;
   wire [bits-1:0][drvrs-1:0][pckg_sz-1:0] dpush_w;

   assign bus.pop    = pop_w;
   assign bus.push   = push_w;
   assign bus.D_push = dpush_w;

   genvar gi;
   generate
      for (gi = 0; gi < bits; gi++) begin : g_bus
         state_t             state_reg;
         logic [PW-1:0]      ptr_reg;
         logic [PW-1:0]      src_reg;
         logic [pckg_sz-1:0] pkt_reg;
         logic [pckg_sz-1:0] dpush_reg;
         logic [drvrs-1:0]   pop_reg;
         logic [drvrs-1:0]   push_reg;

         logic [PW-1:0]      grant_idx;
         logic               grant_any;
         logic [drvrs-1:0]   push_mask;
         logic [7:0]         dst;
         int                 idx;

         // Search starts one past the last winner so every pending device is
         // served before any device wins a second time.
         always_comb begin
            grant_any = 1'b0;
            grant_idx = ptr_reg;
            idx       = 0;
            for (int k = 1; k <= drvrs; k++) begin
               idx = int'(ptr_reg) + k;
               if (idx >= drvrs) begin
                  idx = idx - drvrs;
               end
               if (!grant_any && bus.pndng[gi][idx]) begin
                  grant_any = 1'b1;
                  grant_idx = PW'(idx);
               end
            end
         end

         // Out-of-range destinations match no device, so the packet is dropped.
         always_comb begin
            push_mask = '0;
            dst       = pkt_reg[pckg_sz-1 -: 8];
            for (int d = 0; d < drvrs; d++) begin
               if (dst == broadcast) begin
                  push_mask[d] = (PW'(d) != src_reg);
               end else begin
                  push_mask[d] = (dst == 8'(d));
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               state_reg <= IDLE;
               ptr_reg   <= PW'(drvrs - 1);
               src_reg   <= '0;
               pkt_reg   <= '0;
               dpush_reg <= '0;
               pop_reg   <= '0;
               push_reg  <= '0;
            end else begin
               case (state_reg)
                  IDLE: begin
                     push_reg <= '0;
                     if (grant_any) begin
                        src_reg   <= grant_idx;
                        ptr_reg   <= grant_idx;
                        pkt_reg   <= bus.D_pop[gi][grant_idx];
                        pop_reg   <= {{(drvrs-1){1'b0}}, 1'b1} << grant_idx;
                        state_reg <= POP;
                     end else begin
                        pop_reg <= '0;
                     end
                  end
                  POP: begin
                     pop_reg   <= '0;
                     dpush_reg <= pkt_reg;
                     push_reg  <= push_mask;
                     state_reg <= PUSH;
                  end
                  PUSH: begin
                     push_reg  <= '0;
                     state_reg <= IDLE;
                  end
                  default: begin
                     pop_reg   <= '0;
                     push_reg  <= '0;
                     state_reg <= IDLE;
                  end
               endcase
            end
         end

         assign pop_w[gi]   = pop_reg;
         assign push_w[gi]  = push_reg;
         assign dpush_w[gi] = {drvrs{dpush_reg}};
      end
   endgenerate

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Directed bench for the shared-bus arbiter: reset, unicast, broadcast, fairness,
// dropped packets and reset in the middle of a transaction.
module tb_bus_generator_arbiter;

   localparam int BITS = 1;
   localparam int DRV  = 4;
   localparam int PSZ  = 16;

   logic clk;
   logic reset;

   int n_cmp;
   int n_err;

   bus_generator_arbiter_if #(.bits(BITS), .drvrs(DRV), .pckg_sz(PSZ)) bus ();

   bus_generator_arbiter #(
      .bits(BITS), .drvrs(DRV), .pckg_sz(PSZ), .broadcast(8'hFF)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int       g;
      int       dst_dev;
      logic [15:0] pkt;

      n_cmp = 0;
      n_err = 0;

      reset = 1'b0;
      bus.pndng = 4'b1111;
      bus.D_pop[0][0] = 16'h0311;
      bus.D_pop[0][1] = 16'h0000;
      bus.D_pop[0][2] = 16'h0000;
      bus.D_pop[0][3] = 16'h0000;

      // Held in reset with every device pending.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_pop", 32'(bus.pop[0]), 32'h0);
         check("rst_push", 32'(bus.push[0]), 32'h0);
      end
      check("rst_dpush0", 32'(bus.D_push[0][0]), 32'h0);
      check("rst_dpush3", 32'(bus.D_push[0][3]), 32'h0);

      reset = 1'b1;
      tick();
      check("first_grant", 32'(bus.pop[0]), 32'h1);
      bus.pndng = 4'b0000;
      tick();
      check("first_pop_clr", 32'(bus.pop[0]), 32'h0);
      check("first_push", 32'(bus.push[0]), 32'h8);
      check("first_dpush3", 32'(bus.D_push[0][3]), 32'h0311);
      tick();
      check("first_push_clr", 32'(bus.push[0]), 32'h0);
      $display("txn reset/first: src 0 pkt 0311");

      // Unicast from device 1 to device 2.
      bus.pndng = 4'b0010;
      bus.D_pop[0][1] = 16'h02AB;
      tick();
      check("uc_pop", 32'(bus.pop[0]), 32'h2);
      bus.pndng = 4'b0000;
      tick();
      check("uc_pop_clr", 32'(bus.pop[0]), 32'h0);
      check("uc_push", 32'(bus.push[0]), 32'h4);
      check("uc_dpush2", 32'(bus.D_push[0][2]), 32'h02AB);
      check("uc_dpush0", 32'(bus.D_push[0][0]), 32'h02AB);
      tick();
      check("uc_push_clr", 32'(bus.push[0]), 32'h0);
      tick();
      check("uc_idle_pop", 32'(bus.pop[0]), 32'h0);
      check("uc_dpush_hold", 32'(bus.D_push[0][1]), 32'h02AB);
      $display("txn unicast: src 1 pkt 02AB");

      // Broadcast from device 3 reaches everyone but the source.
      bus.pndng = 4'b1000;
      bus.D_pop[0][3] = 16'hFF5A;
      tick();
      check("bc_pop", 32'(bus.pop[0]), 32'h8);
      bus.pndng = 4'b0000;
      tick();
      check("bc_push", 32'(bus.push[0]), 32'h7);
      check("bc_dpush1", 32'(bus.D_push[0][1]), 32'hFF5A);
      tick();
      check("bc_push_clr", 32'(bus.push[0]), 32'h0);
      $display("txn broadcast: src 3 pkt FF5A");

      // All pending: device i sends to device (i+1)%4.
      for (int i = 0; i < DRV; i++) begin
         bus.D_pop[0][i] = {8'((i + 1) % DRV), 8'(8'h30 + i)};
      end
      bus.pndng = 4'b1111;
      for (int t = 0; t < 12; t++) begin
         g       = t % DRV;
         dst_dev = (g + 1) % DRV;
         pkt     = {8'(dst_dev), 8'(8'h30 + g)};
         tick();
         check("rr_pop", 32'(bus.pop[0]), 32'h1 << g);
         tick();
         check("rr_pop_clr", 32'(bus.pop[0]), 32'h0);
         check("rr_push", 32'(bus.push[0]), 32'h1 << dst_dev);
         check("rr_dpush", 32'(bus.D_push[0][dst_dev]), 32'(pkt));
         tick();
         check("rr_push_clr", 32'(bus.push[0]), 32'h0);
         $display("txn rr %0d: src %0d dst %0d pkt %04h", t, g, dst_dev, pkt);
      end

      // Destination 7 does not exist: pop happens, nobody is pushed.
      bus.pndng = 4'b0001;
      bus.D_pop[0][0] = 16'h0711;
      tick();
      check("drop_pop", 32'(bus.pop[0]), 32'h1);
      bus.pndng = 4'b0000;
      tick();
      check("drop_push", 32'(bus.push[0]), 32'h0);
      check("drop_pop_clr", 32'(bus.pop[0]), 32'h0);
      tick();
      check("drop_push_idle", 32'(bus.push[0]), 32'h0);
      $display("txn drop: src 0 pkt 0711");

      bus.pndng = 4'b0100;
      bus.D_pop[0][2] = 16'h0155;
      tick();
      check("after_drop_pop", 32'(bus.pop[0]), 32'h4);
      bus.pndng = 4'b0000;
      tick();
      check("after_drop_push", 32'(bus.push[0]), 32'h2);
      check("after_drop_dpush", 32'(bus.D_push[0][1]), 32'h0155);
      tick();
      $display("txn after drop: src 2 pkt 0155");

      // Reset while pop is high aborts the packet and rewinds the pointer.
      bus.pndng = 4'b0010;
      bus.D_pop[0][1] = 16'h0099;
      tick();
      check("abort_pop", 32'(bus.pop[0]), 32'h2);
      reset = 1'b0;
      tick();
      check("abort_push", 32'(bus.push[0]), 32'h0);
      check("abort_pop_clr", 32'(bus.pop[0]), 32'h0);
      check("abort_dpush", 32'(bus.D_push[0][0]), 32'h0);
      reset = 1'b1;
      bus.pndng = 4'b1111;
      bus.D_pop[0][0] = 16'h0222;
      tick();
      check("abort_regrant", 32'(bus.pop[0]), 32'h1);
      bus.pndng = 4'b0000;
      tick();
      check("abort_regrant_push", 32'(bus.push[0]), 32'h4);
      check("abort_regrant_dpush", 32'(bus.D_push[0][2]), 32'h0222);
      tick();
      check("abort_regrant_clr", 32'(bus.push[0]), 32'h0);
      $display("txn abort/regrant: src 0 pkt 0222");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
